// File: rtl/regfile_write_scheduler.sv
// Writeback scheduler for a single-write-port register file: serialises the
// valE and valM writes of one retired instruction, then pulses wb_done.
module regfile_write_scheduler #(
  parameter logic [3:0] RSP_IDX  = 4'd4,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cond,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        wb_done,
  output logic [31:0] commit_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR_E = 2'd1;
  localparam logic [1:0] WR_M = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  icode_q, ra_q, rb_q;
  logic        cond_q;
  logic [63:0] val_e_q, val_m_q;
  logic [3:0]  in_dst_e, in_dst_m, cap_dst_e, cap_dst_m;
  logic        accept;

  function automatic logic [3:0] dst_m_of(input logic [3:0] ic, input logic [3:0] ra);
    logic [3:0] m;
    m = REG_NONE;
    if (ic == 4'h5 || ic == 4'hB) m = ra;
    return m;
  endfunction

  // A shared destination keeps only the valM write (popq %rsp).
  function automatic logic [3:0] dst_e_of(input logic [3:0] ic, input logic c,
                                          input logic [3:0] ra, input logic [3:0] rb);
    logic [3:0] e;
    logic [3:0] m;
    e = REG_NONE;
    case (ic)
      4'h2:                   e = c ? rb : REG_NONE;
      4'h3, 4'h6:             e = rb;
      4'h8, 4'h9, 4'hA, 4'hB: e = RSP_IDX;
      default:                e = REG_NONE;
    endcase
    m = dst_m_of(ic, ra);
    if (e != REG_NONE && e == m) e = REG_NONE;
    return e;
  endfunction

  assign in_dst_e  = dst_e_of(icode, cond, rA, rB);
  assign in_dst_m  = dst_m_of(icode, rA);
  assign cap_dst_e = dst_e_of(icode_q, cond_q, ra_q, rb_q);
  assign cap_dst_m = dst_m_of(icode_q, ra_q);

  assign wb_ready = (state_q == IDLE);
  assign accept   = wb_valid && wb_ready;
  assign wb_done  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          if (in_dst_e != REG_NONE)      state_d = WR_E;
          else if (in_dst_m != REG_NONE) state_d = WR_M;
          else                           state_d = DONE;
        end
      end
      WR_E:    state_d = (cap_dst_m != REG_NONE) ? WR_M : DONE;
      WR_M:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port is decoded from state and captured fields only.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = 64'd0;
    case (state_q)
      WR_E: begin
        rf_we    = 1'b1;
        rf_waddr = cap_dst_e;
        rf_wdata = val_e_q;
      end
      WR_M: begin
        rf_we    = 1'b1;
        rf_waddr = cap_dst_m;
        rf_wdata = val_m_q;
      end
      default: ;
    endcase
  end

  // commit_cnt bumps on entry to DONE so it already reflects the request while wb_done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      icode_q    <= 4'd0;
      ra_q       <= 4'd0;
      rb_q       <= 4'd0;
      cond_q     <= 1'b0;
      val_e_q    <= 64'd0;
      val_m_q    <= 64'd0;
      commit_cnt <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        icode_q <= icode;
        ra_q    <= rA;
        rb_q    <= rB;
        cond_q  <= cond;
        val_e_q <= valE;
        val_m_q <= valM;
      end
      if (state_d == DONE && state_q != DONE) commit_cnt <= commit_cnt + 32'd1;
    end
  end

endmodule
